// File: rtl/psm_pkg.sv
// Shared types and arithmetic helpers for the PSM setpoint ramp.
// Helpers work on 32-bit signed values; callers size their operands in and out.
package psm_pkg;

    localparam int PSM_BITS_DATA = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } psm_state_t;

    typedef struct packed {
        logic        sign;
        logic [31:0] mag;
    } sign_mag_t;

    // Saturate value to [-lim, +lim]; lim is a non-negative count below 2^31.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input logic [31:0] lim);
        logic signed [31:0] hi;
        hi = $signed(lim);
        if (value > hi)
            return hi;
        if (value < -hi)
            return -hi;
        return value;
    endfunction

    function automatic sign_mag_t to_sign_mag(input logic signed [31:0] value);
        sign_mag_t sm;
        sm.sign = (value < 0);
        sm.mag  = sm.sign ? $unsigned(-value) : $unsigned(value);
        return sm;
    endfunction

endpackage

// File: rtl/psm_axis_ramp.sv
// One ramp axis: saturated target register, per-period step toward it, sign/magnitude out.
// Latency: target registered one cycle after raw changes; current moves on the tick edge.
// Backpressure: none; raw is sampled every cycle.
module psm_axis_ramp
    import psm_pkg::*;
#(
    parameter int BITS_DATA = PSM_BITS_DATA
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic signed [BITS_DATA-1:0] raw,
    input  logic        [BITS_DATA-1:0] lim,
    input  logic                        enable,
    input  logic        [BITS_DATA-1:0] step,
    input  logic                        tick,
    output logic                        sat_hit,
    output logic                        at_target,
    output logic                        reach,
    output logic        [BITS_DATA-1:0] value,
    output logic                        sign
);

    localparam int W = BITS_DATA + 1;

    logic signed [31:0]  raw32, sat32, tgt32, cur32, d32, absd32, step32;
    logic signed [W-1:0] target, current, cur_next, tgt_next;
    sign_mag_t           sm;
    logic                unused_mag_hi;

    assign raw32    = 32'(raw);
    assign sat32    = sat_signed(raw32, 32'(lim));
    assign sat_hit  = (sat32 != raw32);
    assign tgt_next = enable ? W'(sat32) : '0;

    assign tgt32  = 32'(target);
    assign cur32  = 32'(current);
    assign d32    = tgt32 - cur32;
    assign absd32 = (d32 < 0) ? -d32 : d32;
    assign step32 = $signed(32'(step));

    always_comb begin
        cur_next = current;
        if (tick) begin
            if (step == '0 || absd32 <= step32)
                cur_next = target;
            else if (d32 < 0)
                cur_next = current - $signed({1'b0, step});
            else
                cur_next = current + $signed({1'b0, step});
        end
    end

    // reach: after this cycle's (possible) step, current sits on the target
    assign reach     = (cur_next == target);
    assign at_target = (current == target);

    always_ff @(posedge CLK) begin
        if (RST) begin
            target  <= '0;
            current <= '0;
        end else begin
            target  <= tgt_next;
            current <= cur_next;
        end
    end

    assign sm            = to_sign_mag(cur32);
    assign value         = sm.mag[BITS_DATA-1:0];
    assign sign          = sm.sign;
    assign unused_mag_hi = ^sm.mag[31:BITS_DATA];

endmodule

// File: rtl/psm_setpoint_ramp.sv
// Command intake, clamp flag, mode bit and ramp FSM for the PSM setpoints.
// Latency: target valid one cycle after accept; outputs move the cycle after a period tick.
// Backpressure: never; oCMD_ready is constant 1 and a new command overrides the old one.
module psm_setpoint_ramp
    import psm_pkg::*;
#(
    parameter int BITS_DATA = PSM_BITS_DATA
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 iCMD_valid,
    output logic                 oCMD_ready,
    input  logic [BITS_DATA-1:0] iCMD_SPS,
    input  logic [BITS_DATA-1:0] iCMD_DPS,
    input  logic                 iCMD_N,
    input  logic [BITS_DATA-1:0] iFREQUENCY,
    input  logic [BITS_DATA-1:0] iSTEP,
    input  logic                 iPERIOD_TICK,
    input  logic                 iENABLE,
    output logic [BITS_DATA-1:0] oSPS_value,
    output logic                 oSPS_sign,
    output logic [BITS_DATA-1:0] oDPS_value,
    output logic                 oDPS_sign,
    output logic                 oN,
    output logic                 oBUSY,
    output logic                 oAT_TARGET,
    output logic                 oCLAMP
);

    logic [BITS_DATA-1:0] cmd_sps, cmd_dps, sel_sps, sel_dps, lim;
    logic                 cmd_n, accept;
    logic                 sps_sat, dps_sat, sps_at, dps_at, sps_reach, dps_reach;
    logic                 both_reach, settled;
    psm_state_t           state;

    assign oCMD_ready = 1'b1;
    assign accept     = iCMD_valid;
    assign lim        = iFREQUENCY >> 1;

    // An accepting cycle feeds the new command straight to the target registers
    assign sel_sps = accept ? iCMD_SPS : cmd_sps;
    assign sel_dps = accept ? iCMD_DPS : cmd_dps;

    psm_axis_ramp #(.BITS_DATA(BITS_DATA)) u_sps (
        .CLK(CLK), .RST(RST), .raw($signed(sel_sps)), .lim(lim), .enable(iENABLE),
        .step(iSTEP), .tick(iPERIOD_TICK), .sat_hit(sps_sat), .at_target(sps_at),
        .reach(sps_reach), .value(oSPS_value), .sign(oSPS_sign)
    );

    psm_axis_ramp #(.BITS_DATA(BITS_DATA)) u_dps (
        .CLK(CLK), .RST(RST), .raw($signed(sel_dps)), .lim(lim), .enable(iENABLE),
        .step(iSTEP), .tick(iPERIOD_TICK), .sat_hit(dps_sat), .at_target(dps_at),
        .reach(dps_reach), .value(oDPS_value), .sign(oDPS_sign)
    );

    assign both_reach = sps_reach && dps_reach;
    // On a tick the post-step position decides; otherwise the present one does
    assign settled    = iPERIOD_TICK ? both_reach : (sps_at && dps_at);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_sps    <= '0;
            cmd_dps    <= '0;
            cmd_n      <= 1'b0;
            oCLAMP     <= 1'b0;
            oN         <= 1'b0;
            state      <= IDLE;
            oBUSY      <= 1'b0;
            oAT_TARGET <= 1'b1;
        end else begin
            if (accept) begin
                cmd_sps <= iCMD_SPS;
                cmd_dps <= iCMD_DPS;
                cmd_n   <= iCMD_N;
                oCLAMP  <= sps_sat || dps_sat;
            end
            if (iPERIOD_TICK && both_reach)
                oN <= cmd_n;
            case (state)
                IDLE: if (!settled) begin
                    state      <= RAMP;
                    oBUSY      <= 1'b1;
                    oAT_TARGET <= 1'b0;
                end
                RAMP: if (iPERIOD_TICK && both_reach) begin
                    state      <= IDLE;
                    oBUSY      <= 1'b0;
                    oAT_TARGET <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psm_setpoint_ramp.sv
// Directed bench for psm_setpoint_ramp with hand-computed expectations.
module tb_psm_setpoint_ramp;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iCMD_valid;
    logic        oCMD_ready;
    logic [15:0] iCMD_SPS, iCMD_DPS;
    logic        iCMD_N;
    logic [15:0] iFREQUENCY, iSTEP;
    logic        iPERIOD_TICK, iENABLE;
    logic [15:0] oSPS_value, oDPS_value;
    logic        oSPS_sign, oDPS_sign, oN, oBUSY, oAT_TARGET, oCLAMP;

    int checks   = 0;
    int failures = 0;

    psm_setpoint_ramp #(.BITS_DATA(16)) dut (
        .CLK(CLK), .RST(RST), .iCMD_valid(iCMD_valid), .oCMD_ready(oCMD_ready),
        .iCMD_SPS(iCMD_SPS), .iCMD_DPS(iCMD_DPS), .iCMD_N(iCMD_N),
        .iFREQUENCY(iFREQUENCY), .iSTEP(iSTEP), .iPERIOD_TICK(iPERIOD_TICK),
        .iENABLE(iENABLE), .oSPS_value(oSPS_value), .oSPS_sign(oSPS_sign),
        .oDPS_value(oDPS_value), .oDPS_sign(oDPS_sign), .oN(oN), .oBUSY(oBUSY),
        .oAT_TARGET(oAT_TARGET), .oCLAMP(oCLAMP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One-cycle accept; returns 1 ns after the accepting edge (t+1)
    task automatic accept(input int sps, input int dps, input logic n);
        @(posedge CLK); #1;
        iCMD_valid = 1'b1;
        iCMD_SPS   = 16'(sps);
        iCMD_DPS   = 16'(dps);
        iCMD_N     = n;
        @(posedge CLK); #1;
        iCMD_valid = 1'b0;
    endtask

    // One-cycle tick; returns 1 ns after the ticking edge
    task automatic tick();
        @(posedge CLK); #1;
        iPERIOD_TICK = 1'b1;
        @(posedge CLK); #1;
        iPERIOD_TICK = 1'b0;
    endtask

    task automatic accept_tick(input int sps, input int dps, input logic n);
        @(posedge CLK); #1;
        iCMD_valid   = 1'b1;
        iPERIOD_TICK = 1'b1;
        iCMD_SPS     = 16'(sps);
        iCMD_DPS     = 16'(dps);
        iCMD_N       = n;
        @(posedge CLK); #1;
        iCMD_valid   = 1'b0;
        iPERIOD_TICK = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; iCMD_valid = 1'b0; iCMD_SPS = '0; iCMD_DPS = '0; iCMD_N = 1'b0;
        iFREQUENCY = 16'd2000; iSTEP = 16'd100; iPERIOD_TICK = 1'b0; iENABLE = 1'b1;
        cycles(3);
        RST = 1'b0;
        cycles(1);

        // Reset state
        check("rst_sps_val", oSPS_value, 0);
        check("rst_sps_sign", oSPS_sign, 0);
        check("rst_dps_val", oDPS_value, 0);
        check("rst_dps_sign", oDPS_sign, 0);
        check("rst_n", oN, 0);
        check("rst_at_target", oAT_TARGET, 1);
        check("rst_busy", oBUSY, 0);
        check("rst_ready", oCMD_ready, 1);
        check("rst_clamp", oCLAMP, 0);

        // Ramp with step 100
        accept(300, -100, 1'b1);
        check("ramp_clamp", oCLAMP, 0);
        cycles(1);
        check("ramp_busy", oBUSY, 1);
        check("ramp_at_target", oAT_TARGET, 0);
        tick();
        check("ramp_t1_sps", oSPS_value, 100);
        check("ramp_t1_dps", oDPS_value, 100);
        check("ramp_t1_dps_sign", oDPS_sign, 1);
        check("ramp_t1_n", oN, 0);
        tick();
        check("ramp_t2_sps", oSPS_value, 200);
        check("ramp_t2_busy", oBUSY, 1);
        tick();
        check("ramp_t3_sps", oSPS_value, 300);
        check("ramp_t3_n", oN, 1);
        check("ramp_t3_busy", oBUSY, 0);
        check("ramp_t3_at_target", oAT_TARGET, 1);
        tick();
        check("ramp_t4_sps", oSPS_value, 300);

        // Clamping to half period, re-clamp on frequency drop
        iSTEP = 16'd0;
        accept(1500, 0, 1'b1);
        check("clamp_set", oCLAMP, 1);
        tick();
        check("clamp_sps", oSPS_value, 1000);
        check("clamp_dps", oDPS_value, 0);
        iFREQUENCY = 16'd1200;
        cycles(2);
        tick();
        check("reclamp_sps", oSPS_value, 600);
        accept(200, 0, 1'b1);
        check("clamp_clear", oCLAMP, 0);
        tick();
        check("unclamped_sps", oSPS_value, 200);

        // Zero crossing
        iSTEP = 16'd100;
        accept(50, 0, 1'b1);
        tick();
        check("xing_pre1", oSPS_value, 100);
        tick();
        check("xing_pre2", oSPS_value, 50);
        check("xing_pre2_sign", oSPS_sign, 0);
        accept(-150, 0, 1'b1);
        tick();
        check("xing_t1_val", oSPS_value, 50);
        check("xing_t1_sign", oSPS_sign, 1);
        tick();
        check("xing_t2_val", oSPS_value, 150);
        check("xing_t2_sign", oSPS_sign, 1);

        // Override coinciding with a tick
        iSTEP = 16'd0;
        accept(0, 0, 1'b1);
        tick();
        check("ovr_zero", oSPS_value, 0);
        check("ovr_zero_sign", oSPS_sign, 0);
        iSTEP = 16'd100;
        accept(500, 0, 1'b1);
        tick();
        tick();
        check("ovr_mid", oSPS_value, 200);
        check("ovr_mid_busy", oBUSY, 1);
        accept_tick(100, 0, 1'b1);
        check("ovr_coinc", oSPS_value, 300);
        tick();
        check("ovr_back1", oSPS_value, 200);
        tick();
        check("ovr_back2", oSPS_value, 100);
        check("ovr_busy_done", oBUSY, 0);

        // Enable gating then reset mid-ramp
        iSTEP = 16'd0;
        accept(400, 0, 1'b1);
        tick();
        check("en_start", oSPS_value, 400);
        iSTEP   = 16'd100;
        iENABLE = 1'b0;
        cycles(2);
        tick();
        check("dis_t1", oSPS_value, 300);
        tick();
        check("dis_t2", oSPS_value, 200);
        tick();
        check("dis_t3", oSPS_value, 100);
        tick();
        check("dis_t4", oSPS_value, 0);
        check("dis_busy", oBUSY, 0);
        iENABLE = 1'b1;
        cycles(2);
        tick();
        check("reen_t1", oSPS_value, 100);
        repeat (3) tick();
        check("reen_t4", oSPS_value, 400);
        accept(100, 0, 1'b1);
        tick();
        check("rst_mid_pre", oSPS_value, 300);
        check("rst_mid_pre_busy", oBUSY, 1);
        RST = 1'b1;
        cycles(1);
        check("rst_mid_sps", oSPS_value, 0);
        check("rst_mid_busy", oBUSY, 0);
        check("rst_mid_at_target", oAT_TARGET, 1);
        check("rst_mid_n", oN, 0);
        RST = 1'b0;
        cycles(1);
        check("rst_mid_hold", oSPS_value, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
